// File: rtl/jtag_master_seq.sv
// Host-side JTAG sequencer: turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands into TCK/TMS/TDI sequences.
// Optional macro JTAG_TRST_OUT_EN adds the tap_trst_n output held low through the first five TCKs of RESET.
module jtag_master_seq #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              trst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [3:0]        tap_state,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
`ifdef JTAG_TRST_OUT_EN
  , output logic            tap_trst_n
`endif
);

  localparam int CNT_W = $clog2(DATA_W + (1 << LEN_W) + 8);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] K0  = '0;
  localparam logic [CNT_W-1:0] K1  = CNT_W'(1);
  localparam logic [CNT_W-1:0] K2  = CNT_W'(2);
  localparam logic [CNT_W-1:0] K3  = CNT_W'(3);
  localparam logic [CNT_W-1:0] K4  = CNT_W'(4);
  localparam logic [CNT_W-1:0] K5  = CNT_W'(5);
  localparam logic [CNT_W-1:0] K6  = CNT_W'(6);
  localparam logic [CNT_W-1:0] KDW = CNT_W'(DATA_W);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam logic [3:0] S_SHDR = 4'd4;
  localparam logic [3:0] S_SHIR = 4'd11;

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_READY} state_t;

  state_t state, state_nxt;

  logic [1:0]        op_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  ntck_q;
  logic [CNT_W-1:0]  k_q;
  logic [DIV_W-1:0]  div_q;
  logic [IDX_W:0]    sh_idx_q;
  logic [DATA_W-1:0] data_q;
  logic              in_init_q;

  logic              tick, tck_rise, tck_fall, seq_done, accept;
  logic [CNT_W-1:0]  next_k;
  logic              tms_nxt, tdi_nxt;
  logic [CNT_W-1:0]  len_raw, sh_len, len_eff, ntck_eff;

  // 1149.1 TAP transition in the shared 4-bit state encoding.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    logic [3:0] n;
    n = s;
    case (s)
      4'd0:  n = m ? 4'd0  : 4'd1;
      4'd1:  n = m ? 4'd2  : 4'd1;
      4'd2:  n = m ? 4'd9  : 4'd3;
      4'd3:  n = m ? 4'd5  : 4'd4;
      4'd4:  n = m ? 4'd5  : 4'd4;
      4'd5:  n = m ? 4'd8  : 4'd6;
      4'd6:  n = m ? 4'd7  : 4'd6;
      4'd7:  n = m ? 4'd8  : 4'd4;
      4'd8:  n = m ? 4'd2  : 4'd1;
      4'd9:  n = m ? 4'd0  : 4'd10;
      4'd10: n = m ? 4'd12 : 4'd11;
      4'd11: n = m ? 4'd12 : 4'd11;
      4'd12: n = m ? 4'd15 : 4'd13;
      4'd13: n = m ? 4'd14 : 4'd13;
      4'd14: n = m ? 4'd15 : 4'd11;
      4'd15: n = m ? 4'd2  : 4'd1;
    endcase
    return n;
  endfunction

  // TMS for TCK number k of a sequence starting in RTI.
  function automatic logic tms_for(input logic [1:0] op, input logic [CNT_W-1:0] k,
                                   input logic [CNT_W-1:0] l);
    logic t;
    t = 1'b0;
    case (op)
      OP_RESET: t = (k < K5);
      OP_IR: begin
        if (k < K2)           t = 1'b1;
        else if (k < K4)      t = 1'b0;
        else if (k < l + K4)  t = (k == l + K3);
        else                  t = (k == l + K4);
      end
      OP_DR: begin
        if (k == K0)          t = 1'b1;
        else if (k < K3)      t = 1'b0;
        else if (k < l + K3)  t = (k == l + K2);
        else                  t = (k == l + K3);
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic tdi_for(input logic [1:0] op, input logic [CNT_W-1:0] k,
                                   input logic [CNT_W-1:0] l, input logic [DATA_W-1:0] d);
    logic [CNT_W-1:0] off;
    logic [CNT_W-1:0] s;
    logic             b;
    b   = 1'b0;
    off = (op == OP_IR) ? K4 : K3;
    s   = k - off;
    if ((op == OP_IR || op == OP_DR) && k >= off && k < l + off)
      b = d[IDX_W'(s)];
    return b;
  endfunction

  always_comb begin
    len_raw  = CNT_W'(cmd_len);
    sh_len   = len_raw;
    len_eff  = len_raw;
    ntck_eff = len_raw;
    if (len_raw == K0)      sh_len = K1;
    else if (len_raw > KDW) sh_len = KDW;
    case (cmd_op)
      OP_RESET: begin len_eff = sh_len; ntck_eff = K6;          end
      OP_IR:    begin len_eff = sh_len; ntck_eff = sh_len + K6; end
      OP_DR:    begin len_eff = sh_len; ntck_eff = sh_len + K5; end
      default:  begin len_eff = len_raw; ntck_eff = len_raw;    end
    endcase
  end

  always_comb begin
    tick     = (div_q == DIV_LAST);
    tck_rise = (state == ST_RUN) && tick && !tck;
    tck_fall = (state == ST_RUN) && tick && tck;
    seq_done = tck_fall && (k_q == ntck_q - K1);
    accept   = (state == ST_READY) && cmd_valid;
    next_k   = (state == ST_START) ? K0 : k_q + K1;
    tms_nxt  = tms_for(op_q, next_k, len_q);
    tdi_nxt  = tdi_for(op_q, next_k, len_q, data_q);
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) state <= ST_START;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_START: state_nxt = (ntck_q == K0) ? ST_READY : ST_RUN;
      ST_RUN:   if (seq_done) state_nxt = ST_READY;
      ST_READY: if (accept) state_nxt = ST_START;
      default:  state_nxt = ST_START;
    endcase
  end

  // Command payload needs no reset; it is only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) data_q <= cmd_data;
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      op_q       <= OP_IDLE;
      len_q      <= K1;
      ntck_q     <= K1;
      in_init_q  <= 1'b1;
      k_q        <= K0;
      div_q      <= '0;
      sh_idx_q   <= '0;
      tck        <= 1'b0;
      tms        <= 1'b1;
      tdi        <= 1'b0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      tap_state  <= 4'd0;
`ifdef JTAG_TRST_OUT_EN
      tap_trst_n <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_READY: begin
          if (accept) begin
            op_q      <= cmd_op;
            len_q     <= len_eff;
            ntck_q    <= ntck_eff;
            in_init_q <= 1'b0;
          end
        end
        ST_START: begin
          k_q      <= K0;
          div_q    <= '0;
          sh_idx_q <= '0;
          tck      <= 1'b0;
          tms      <= tms_nxt;
          tdi      <= tdi_nxt;
          if (!in_init_q) rsp_data <= '0;
          if (ntck_q == K0) begin
            rsp_valid <= !in_init_q;
          end else begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
`ifdef JTAG_TRST_OUT_EN
          tap_trst_n <= in_init_q || (op_q != OP_RESET);
`endif
        end
        ST_RUN: begin
          div_q <= tick ? '0 : div_q + DIV_W'(1);
          if (tck_rise) begin
            tck       <= 1'b1;
            tap_state <= tap_next(tap_state, tms);
            if ((tap_state == S_SHDR || tap_state == S_SHIR) && sh_idx_q < (IDX_W+1)'(DATA_W)) begin
              rsp_data[sh_idx_q[IDX_W-1:0]] <= tdo;
              sh_idx_q <= sh_idx_q + (IDX_W+1)'(1);
            end
          end
          if (tck_fall) begin
            tck <= 1'b0;
            k_q <= k_q + K1;
`ifdef JTAG_TRST_OUT_EN
            if (k_q == K4) tap_trst_n <= 1'b1;
`endif
            if (seq_done) begin
              tms       <= 1'b0;
              tdi       <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              rsp_valid <= !in_init_q;
            end else begin
              tms <= tms_nxt;
              tdi <= tdi_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master_seq.sv
// Directed bench for jtag_master_seq at CLK_DIV=2 with a tdi->tdo loopback target.
module tb_jtag_master_seq;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic              clk;
  logic              trst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [3:0]        tap_state;
  logic              tck, tms, tdi, tdo;
  logic              loop_en;
`ifdef JTAG_TRST_OUT_EN
  logic              tap_trst_n;
`endif

  jtag_master_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .trst_n(trst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .tap_state(tap_state),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef JTAG_TRST_OUT_EN
    , .tap_trst_n(tap_trst_n)
`endif
  );

  assign tdo = loop_en ? tdi : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // TMS/TDI log taken at each TCK rising edge.
  logic tms_log [256];
  logic tdi_log [256];
  int   rise_total = 0;
  always @(posedge tck) begin
    tms_log[rise_total % 256] = tms;
    tdi_log[rise_total % 256] = tdi;
    rise_total = rise_total + 1;
  end

  int          lat, n_rise;
  logic [63:0] tms_v, tdi_v;
  logic        saw_tlr, left_rti, busy_e1, ready_e1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and follow it to rsp_valid; lat = edges after E0.
  task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data);
    int base, w;
    w = 0;
    while (!cmd_ready && w < 3000) begin @(negedge clk); w++; end
    chk("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    base = rise_total; saw_tlr = 1'b0; left_rti = 1'b0; lat = -1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_after_E0", {63'd0, cmd_ready}, 64'd1);
    for (int j = 1; j <= 2000; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1) begin busy_e1 = busy; ready_e1 = cmd_ready; end
      if (tap_state == 4'd0) saw_tlr = 1'b1;
      if (tap_state != 4'd1) left_rti = 1'b1;
      if (rsp_valid) begin lat = j; break; end
    end
    n_rise = rise_total - base;
    tms_v = '0; tdi_v = '0;
    for (int i = 0; i < n_rise && i < 64; i++) begin
      tms_v[i] = tms_log[(base + i) % 256];
      tdi_v[i] = tdi_log[(base + i) % 256];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int j;
    logic seen_rsp;
    trst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_data = '0; loop_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tck",       {63'd0, tck},       64'd0);
    chk("rst_tms",       {63'd0, tms},       64'd1);
    chk("rst_tdi",       {63'd0, tdi},       64'd0);
    chk("rst_ready",     {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data",  {32'd0, rsp_data},  64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd1);
    chk("rst_tap_state", {60'd0, tap_state}, 64'd0);

    // Init: one TCK with tms=0, ready 4 clk after tms presentation.
    trst_n = 1'b1;
    j = rise_total;
    @(posedge clk); @(negedge clk);
    chk("init_tms",  {63'd0, tms}, 64'd0);
    chk("init_tck0", {63'd0, tck}, 64'd0);
    repeat (2) begin @(posedge clk); end
    @(negedge clk);
    chk("init_tck_hi", {63'd0, tck},       64'd1);
    chk("init_tap",    {60'd0, tap_state}, 64'd1);
    @(posedge clk); @(negedge clk);
    chk("init_ready_early", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); @(negedge clk);
    chk("init_ready",   {63'd0, cmd_ready}, 64'd1);
    chk("init_busy",    {63'd0, busy},      64'd0);
    chk("init_rises",   64'(rise_total - j), 64'd1);
    chk("init_tms_log", {63'd0, tms_log[j % 256]}, 64'd0);

    // SHIFT_IR len=4 data=0x5
    run_cmd(2'd1, 6'd4, 32'h5);
    chk("ir_busy_e1",  {63'd0, busy_e1},  64'd1);
    chk("ir_ready_e1", {63'd0, ready_e1}, 64'd0);
    chk("ir_lat",      64'(lat),    64'd41);
    chk("ir_ntck",     64'(n_rise), 64'd10);
    chk("ir_tms",      tms_v,       64'h183);
    chk("ir_tdi",      tdi_v,       64'h50);
    chk("ir_rsp",      {32'd0, rsp_data}, 64'h5);
    chk("ir_tap",      {60'd0, tap_state}, 64'd1);
    chk("ir_ready_end", {63'd0, cmd_ready}, 64'd1);
    chk("ir_busy_end",  {63'd0, busy},      64'd0);

    // SHIFT_DR len=32 looped, then with tdo tied low
    run_cmd(2'd2, 6'd32, 32'hDEADBEEF);
    chk("dr_lat",  64'(lat),    64'd149);
    chk("dr_ntck", 64'(n_rise), 64'd37);
    chk("dr_tms",  tms_v,       64'h0000_000C_0000_0001);
    chk("dr_tdi",  tdi_v,       64'h6_F56D_F778);
    chk("dr_rsp",  {32'd0, rsp_data}, 64'hDEADBEEF);
    chk("dr_tap",  {60'd0, tap_state}, 64'd1);
    @(negedge clk);
    chk("dr_rsp_hold", {32'd0, rsp_data}, 64'hDEADBEEF);
    chk("dr_rsp_pulse", {63'd0, rsp_valid}, 64'd0);
    loop_en = 1'b0;
    run_cmd(2'd2, 6'd32, 32'hDEADBEEF);
    chk("dr0_rsp", {32'd0, rsp_data}, 64'h0);
    chk("dr0_lat", 64'(lat), 64'd149);
    loop_en = 1'b1;

    // Length boundaries: 0 treated as 1, over-length clamped
    run_cmd(2'd2, 6'd0, 32'hFFFFFFFF);
    chk("dr_len0_lat", 64'(lat), 64'd25);
    chk("dr_len0_tms", tms_v,    64'h19);
    chk("dr_len0_rsp", {32'd0, rsp_data}, 64'h1);
    run_cmd(2'd2, 6'd63, 32'h12345678);
    chk("dr_len63_lat", 64'(lat), 64'd149);
    chk("dr_len63_rsp", {32'd0, rsp_data}, 64'h12345678);

    // RESET command
    run_cmd(2'd0, 6'd0, 32'h0);
    chk("rst_cmd_lat", 64'(lat), 64'd25);
    chk("rst_cmd_tms", tms_v,    64'h1F);
    chk("rst_cmd_tdi", tdi_v,    64'h0);
    chk("rst_cmd_tlr", {63'd0, saw_tlr}, 64'd1);
    chk("rst_cmd_tap", {60'd0, tap_state}, 64'd1);

    // IDLE 0 and IDLE 3
    run_cmd(2'd3, 6'd0, 32'hA5A5A5A5);
    chk("idle0_lat",   64'(lat),    64'd1);
    chk("idle0_ntck",  64'(n_rise), 64'd0);
    chk("idle0_ready", {63'd0, ready_e1}, 64'd1);
    chk("idle0_rsp",   {32'd0, rsp_data}, 64'h0);
    run_cmd(2'd3, 6'd3, 32'h0);
    chk("idle3_lat",  64'(lat),    64'd13);
    chk("idle3_ntck", 64'(n_rise), 64'd3);
    chk("idle3_tms",  tms_v,       64'h0);
    chk("idle3_stay", {63'd0, left_rti}, 64'd0);

    // Async reset during shift bit 10 of SHIFT_DR
    cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'hCAFEF00D; cmd_valid = 1'b1;
    j = rise_total;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int w = 0; w < 400 && !(rise_total - j >= 14 && tck); w++) @(negedge clk);
    chk("abort_reached", {63'd0, tck}, 64'd1);
    trst_n = 1'b0;
    #1;
    chk("abort_tck",   {63'd0, tck},       64'd0);
    chk("abort_tms",   {63'd0, tms},       64'd1);
    chk("abort_tap",   {60'd0, tap_state}, 64'd0);
    chk("abort_ready", {63'd0, cmd_ready}, 64'd0);
    seen_rsp = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen_rsp = 1'b1; end
    trst_n = 1'b1;
    j = 0;
    for (int w = 1; w <= 50; w++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
      if (cmd_ready) begin j = w; break; end
    end
    chk("abort_no_rsp",   {63'd0, seen_rsp},  64'd0);
    chk("abort_reinit",   64'(j),             64'd5);
    chk("abort_tap_end",  {60'd0, tap_state}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
